// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM states, stall-cause debug codes and parameter defaults.
package hazard_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MULDIV_CYCLES_DEFAULT = 4;
    localparam int MEM_TIMEOUT_DEFAULT   = 64;

    typedef logic [2:0] cause_t;

    localparam cause_t CAUSE_NONE    = 3'd0;
    localparam cause_t CAUSE_MEM     = 3'd1;
    localparam cause_t CAUSE_MULDIV  = 3'd2;
    localparam cause_t CAUSE_BRANCH  = 3'd3;
    localparam cause_t CAUSE_LOADUSE = 3'd4;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: decides load, hold,
// flush or bubble for every pipeline register each cycle.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT,
    parameter int MEM_TIMEOUT   = MEM_TIMEOUT_DEFAULT,
    parameter int STAT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              ex_muldiv,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              stat_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_bubble,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              muldiv_done,
    output logic              mem_error,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nx;
    logic [WAIT_W-1:0] wait_cnt;
    cause_t            cause;
    logic              mem_stall;
    logic              load_use;
    logic              freeze;

    assign mem_stall = mem_req & ~mem_ack;

    assign load_use = ex_mem_read & (ex_rt != REG_ZERO) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign freeze = ((state == RUN) & ex_muldiv) |
                    ((state == MULDIV) & (cnt != 8'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The countdown keeps running under a mem stall; only release waits.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN: begin
                if (ex_muldiv && !mem_stall) begin
                    state_nx = MULDIV;
                    cnt_nx   = CNT_INIT;
                end
            end
            MULDIV: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (!mem_stall) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        priority case (1'b1)
            mem_stall:       cause = CAUSE_MEM;
            freeze:          cause = CAUSE_MULDIV;
            ex_branch_taken: cause = CAUSE_BRANCH;
            load_use:        cause = CAUSE_LOADUSE;
            default:         cause = CAUSE_NONE;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        muldiv_done  = (state == MULDIV) && (cnt == 8'd0) && !mem_stall;
        unique case (cause)
            CAUSE_MEM: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_write = 1'b0;
            end
            CAUSE_MULDIV: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end
            CAUSE_BRANCH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            CAUSE_LOADUSE: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_write  = 1'b0;
            id_ex_bubble = 1'b1;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            muldiv_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else if (mem_stall) begin
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt == WAIT_LAST) begin
                mem_error <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    sat_counter #(
        .W(STAT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (stat_clr),
        .inc  (~pc_write),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, hand sequences
// and random traffic against an event-level reference model.
module tb_hazard_stall_controller;

    localparam int M  = 4;
    localparam int TO = 64;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          id_uses_rt = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [4:0]    ex_rt = '0;
    logic          ex_muldiv = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ack = 1'b0;
    logic          stat_clr = 1'b0;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_write;
    logic          id_ex_bubble;
    logic          ex_mem_write;
    logic          mem_wb_write;
    logic          muldiv_done;
    logic          mem_error;
    logic [SW-1:0] stall_cycles;
    logic [7:0]    outs;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    bit m_active;
    int m_age;
    int m_wait;
    bit m_err;
    int m_stall;

    hazard_stall_controller #(
        .MULDIV_CYCLES(M),
        .MEM_TIMEOUT  (TO),
        .STAT_W       (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .ex_muldiv      (ex_muldiv),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .stat_clr       (stat_clr),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_write   (ex_mem_write),
        .mem_wb_write   (mem_wb_write),
        .muldiv_done    (muldiv_done),
        .mem_error      (mem_error),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write,
                   id_ex_bubble, ex_mem_write, mem_wb_write, muldiv_done};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs {pc,ifid,flush,idex,bubble,exmem,memwb,done}
    function automatic logic [7:0] model_out();
        bit mstall;
        bit lu;
        bit frz;
        bit done;
        mstall = mem_req && !mem_ack;
        lu = ex_mem_read && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        frz = (!m_active && ex_muldiv) || (m_active && m_age < M - 1);
        done = m_active && m_age >= M - 1 && !mstall;
        if (mstall) return 8'b0000_0000;
        if (frz) return 8'b0000_0010;
        if (ex_branch_taken) return {7'b1111_111, done};
        if (lu) return {7'b0001_111, done};
        return {7'b1101_011, done};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_age = 0;
        m_wait = 0;
        m_err = 0;
        m_stall = 0;
    endtask

    task automatic model_step(input logic [7:0] m);
        bit mstall;
        mstall = mem_req && !mem_ack;
        if (stat_clr) m_stall = 0;
        else if (!m[7] && m_stall < (1 << SW) - 1) m_stall++;
        if (mstall) m_wait++;
        else m_wait = 0;
        if (m_wait >= TO) m_err = 1;
        if (m_active) begin
            if (m_age >= M - 1 && !mstall) m_active = 0;
            else m_age++;
        end else if (ex_muldiv && !mstall) begin
            m_active = 1;
            m_age = 1;
        end
    endtask

    // Called just after a rising edge with inputs already set.
    task automatic apply(input string name, input logic [7:0] exp);
        logic [7:0] m;
        #2;
        m = model_out();
        chk(name, {24'd0, outs}, {24'd0, exp});
        chk({name, "_stat"}, {15'd0, mem_error, stall_cycles},
            {15'd0, m_err, 16'(m_stall)});
        @(posedge clk);
        model_step(m);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
        ex_muldiv = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
        stat_clr = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("reset_outs", {24'd0, outs}, 32'h08);
        chk("reset_stat", {15'd0, mem_error, stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mread;
        logic [4:0] ert;
        logic       md;
        logic       br;
        logic       mreq;
        logic       mack;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic [4:0] rs, rt,
                       input logic uses, mread, input logic [4:0] ert,
                       input logic md, br, mreq, mack,
                       input logic [7:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses = uses; v.mread = mread;
        v.ert = ert; v.md = md; v.br = br; v.mreq = mreq; v.mack = mack;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #3;
        do_reset();

        add("lu_rs",      8, 0, 0, 1, 8, 0, 0, 0, 0, 8'b0001_1110);
        add("after_lu",   8, 0, 0, 0, 8, 0, 0, 0, 0, 8'b1101_0110);
        add("lu_rt",      1, 8, 1, 1, 8, 0, 0, 0, 0, 8'b0001_1110);
        add("rt_unused",  1, 8, 0, 1, 8, 0, 0, 0, 0, 8'b1101_0110);
        add("zero_reg",   0, 0, 1, 1, 0, 0, 0, 0, 0, 8'b1101_0110);
        add("no_mread",   8, 8, 1, 0, 8, 0, 0, 0, 0, 8'b1101_0110);
        add("br_lu",      8, 0, 0, 1, 8, 0, 1, 0, 0, 8'b1111_1110);
        add("br_only",    3, 4, 1, 0, 9, 0, 1, 0, 0, 8'b1111_1110);
        add("mem_stall",  3, 4, 0, 0, 0, 0, 0, 1, 0, 8'b0000_0000);
        add("mem_ack",    3, 4, 0, 0, 0, 0, 0, 1, 1, 8'b1101_0110);
        add("stall_all",  8, 0, 0, 1, 8, 0, 1, 1, 0, 8'b0000_0000);
        add("md_mstall",  0, 0, 0, 0, 0, 1, 0, 1, 0, 8'b0000_0000);
        add("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1101_0110);

        foreach (tbl[i]) begin
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_uses_rt = tbl[i].uses;
            ex_mem_read = tbl[i].mread; ex_rt = tbl[i].ert;
            ex_muldiv = tbl[i].md; ex_branch_taken = tbl[i].br;
            mem_req = tbl[i].mreq; mem_ack = tbl[i].mack;
            apply(tbl[i].name, tbl[i].exp);
            if (i == 0) chk("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);
        end

        // mul/div: three frozen cycles then release pulse
        idle_inputs();
        ex_muldiv = 1;
        for (int k = 0; k < M - 1; k++) apply("md_freeze", 8'b0000_0010);
        apply("md_release", 8'b1101_0111);
        ex_muldiv = 0;
        apply("md_after", 8'b1101_0110);

        // release held off by a memory stall
        ex_muldiv = 1;
        for (int k = 0; k < M - 1; k++) apply("md2_freeze", 8'b0000_0010);
        mem_req = 1;
        apply("md2_hold", 8'b0000_0000);
        mem_ack = 1;
        apply("md2_release", 8'b1101_0111);
        idle_inputs();

        // memory wait with a pending branch
        mem_req = 1; ex_branch_taken = 1;
        for (int k = 0; k < 5; k++) apply("mw_stall", 8'b0000_0000);
        mem_ack = 1;
        apply("mw_flush", 8'b1111_1110);
        chk("mw_no_err", {31'd0, mem_error}, 32'd0);
        idle_inputs();

        // timeout boundary: 63 stalls clean, 64 stalls set the flag
        mem_req = 1;
        for (int k = 0; k < TO - 1; k++) apply("to63", 8'b0000_0000);
        mem_ack = 1;
        apply("to63_ack", 8'b1101_0110);
        chk("to63_no_err", {31'd0, mem_error}, 32'd0);
        mem_ack = 0;
        for (int k = 0; k < TO; k++) apply("to64", 8'b0000_0000);
        mem_ack = 1;
        apply("to64_ack", 8'b1101_0110);
        idle_inputs();
        apply("to_idle", 8'b1101_0110);
        chk("to_err_sticky", {31'd0, mem_error}, 32'd1);

        stat_clr = 1;
        ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        apply("clr_vs_inc", 8'b0001_1110);
        chk("clr_prio", {16'd0, stall_cycles}, 32'd0);
        idle_inputs();

        // reset during mul/div cycle 2
        ex_muldiv = 1;
        apply("rmd_c1", 8'b0000_0010);
        #2;
        reset = 1'b0;
        #1;
        chk("rmd_outs", {24'd0, outs}, 32'h08);
        chk("rmd_stat", {15'd0, mem_error, stall_cycles}, 32'd0);
        @(posedge clk);
        #1;
        ex_muldiv = 0;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < M; k++) apply("rmd_run", 8'b1101_0110);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_muldiv = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ack = 1'($urandom_range(0, 1));
            stat_clr = ($urandom_range(0, 49) == 0);
            apply("rand", model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Each cycle it decides which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, hold, flush or take a bubble.
- Hazard sources: load-use data hazards, taken branches resolved in EX, multi-cycle mul/div ops occupying EX, and data-memory wait states.
- It sits beside the decode stage. It drives the new enable/bubble inputs of the pipeline registers and the PC write enable.

Parameters:
- MULDIV_CYCLES, 4: total cycles a mul/div op occupies EX; legal values are 2 to 255.
- MEM_TIMEOUT, 64: consecutive memory-wait cycles before mem_error is set.
- STAT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt as a source.
- ex_mem_read  in  1  MemRead of the instruction in EX (ID/EX output).
- ex_rt  in  5  rt of the instruction in EX (load destination).
- ex_muldiv  in  1  instruction in EX is a multi-cycle mul/div.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- stat_clr  in  1  synchronous clear of stall_cycles.
- pc_write  out  1  PC loads its next value.
- if_id_write  out  1  IF/ID register loads.
- if_id_flush  out  1  IF/ID loads a NOP; only meaningful when if_id_write=1.
- id_ex_write  out  1  ID/EX register loads.
- id_ex_bubble  out  1  ID/EX loads all-zero control fields.
- ex_mem_write  out  1  EX/MEM register loads.
- mem_wb_write  out  1  MEM/WB register loads.
- muldiv_done  out  1  one-cycle pulse on the mul/div release cycle.
- mem_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  STAT_W  saturating count of cycles with pc_write=0.

Behaviour:
Reset:
- While reset=0, state=RUN, mul/div count=0, wait count=0, stall_cycles=0, mem_error=0.
- Outputs forced while reset=0: all *_write=0, if_id_flush=0, id_ex_bubble=1, muldiv_done=0.

State machine (RUN, MULDIV):
- RUN with ex_muldiv=1 and no mem stall: load cnt=MULDIV_CYCLES-2, go to MULDIV.
- MULDIV with cnt!=0: decrement; the count continues even during a mem stall.
- MULDIV with cnt==0 and no mem stall: release cycle. muldiv_done=1, go to RUN.
- MULDIV with cnt==0 during a mem stall: stay in MULDIV until the stall clears.
- Result: the op occupies EX for exactly MULDIV_CYCLES cycles when there is no memory stall.

Output priority, evaluated combinationally each cycle; the first match wins:
1. mem_stall = mem_req & ~mem_ack. All five *_write=0, flush=0, bubble=0.
2. mul/div freeze (RUN & ex_muldiv, or MULDIV & cnt!=0). pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_write=1; flush=0; bubble=0.
3. ex_branch_taken. All writes=1, if_id_flush=1, id_ex_bubble=1. The branch squashes any simultaneous load-use stall.
4. Load-use: ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). pc_write=0, if_id_write=0, id_ex_bubble=1; all other writes=1. Lasts exactly one cycle.
5. Otherwise all writes=1, flush=0, bubble=0.

Pending events:
- A taken branch frozen by case 1 or 2 stays in EX, because ID/EX is held. Its flush is applied on the first unfrozen cycle.

Memory timeout:
- The wait counter increments each mem_stall cycle and clears on any non-stall cycle.
- Reaching MEM_TIMEOUT sets mem_error, which stays set until reset. Stalling continues; the controller never drops the request.

stall_cycles:
- Increments on each cycle with pc_write=0 and saturates at all-ones.
- stat_clr=1 clears it to 0 and has priority over the increment.

Reset mid-operation:
- Asserting reset in MULDIV aborts the op: state returns to RUN and no muldiv_done is issued.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum (RUN, MULDIV);
  - REG_ZERO=5'd0;
  - MULDIV_CYCLES and MEM_TIMEOUT defaults;
  - an encoded stall-cause constant set (NONE, MEM, MULDIV, BRANCH, LOADUSE), for debug taps.
- One sub-module: sat_counter (STAT_W-wide saturating counter with sync clear), used for stall_cycles.

Test Plan:
- Load-use hazard: lw $t0 in EX (ex_mem_read=1, ex_rt=8) and id_rs=8 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; normal flow next cycle; stall_cycles=1.
- Register $zero: ex_rt=0 with id_rs=0 and ex_mem_read=1 -> no stall.
- Mul/div: ex_muldiv=1 with MULDIV_CYCLES=4 -> freeze for 3 cycles with mem_wb_write=1; muldiv_done pulses on cycle 4; RUN afterwards.
- Taken branch plus load-use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall.
- Memory wait: mem_req=1 with mem_ack low for 5 cycles while a branch is taken in EX -> all writes 0 for 5 cycles; flush is issued on the cycle mem_ack=1; mem_error stays 0.
- Memory timeout: mem_ack held low for 64 cycles -> mem_error=1 and remains set after the ack.
- Reset mid-op: reset pulsed low during MULDIV cycle 2 -> outputs take their reset values immediately; after release the state is RUN and no muldiv_done pulse occurs.
